// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed scan controller for NDIG common-anode
// digits sharing one BCD-to-7-segment decoder. A shadow register takes new
// values at any time; the displayed (active) value is swapped only at the
// frame wrap, so a displayed frame never mixes two loads.
// There is no valid/ready handshake: `load` is a single-cycle strobe that is
// always accepted, and the newest strobe wins.
module bcd_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] din,
  input  logic              lzb,
  output logic [0:3]        z,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame,
  output logic              dbg_state
);

  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_wrap;

  logic [4*NDIG-1:0]   r_active;
  logic [4*NDIG-1:0]   r_shadow;
  logic                r_pending;
  logic                r_frame;

  logic [3:0]          w_digit;
  logic                w_zero_above;
  logic                w_suppress;

  // Scan state register: reset parks in BLANK on the last digit so the
  // first wrap lands BLANK clocks after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_idx   <= IDX_LAST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: SHOW for DIV clocks, BLANK for BLANK clocks, advance digit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (r_cnt == DIV_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Double buffer: swap at the wrap only; a load on the wrap edge still
  // leaves the new value pending for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_active <= r_shadow;
      end
      if (load) begin
        r_shadow  <= din;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
      r_frame <= w_wrap;
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  always_comb begin
    w_digit      = '0;
    w_zero_above = 1'b1;
    w_suppress   = 1'b0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (r_active[4*k +: 4] == 4'd0);
      if (IW'(k) == r_idx) begin
        w_digit    = r_active[4*k +: 4];
        w_suppress = lzb && (k != 0) && w_zero_above;
      end
    end
  end

  // Moore output decode: one anode low during SHOW, everything off in BLANK.
  always_comb begin
    an = '1;
    z  = 4'b1111;
    if (r_state == ST_SHOW) begin
      for (int k = 0; k < NDIG; k++) begin
        if (IW'(k) == r_idx) begin
          an[k] = 1'b0;
        end
      end
      z = w_suppress ? 4'b1111 : w_digit;
    end
  end

  assign pending   = r_pending;
  assign frame     = r_frame;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a timeline model
// that derives the display position from the edge count since reset.
module tb_bcd_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int DP    = DIV + BLANK;
  localparam int FP    = NDIG * DP;
  localparam int W     = 10;

  logic              clk;
  logic              rst_n;
  logic              load;
  logic [4*NDIG-1:0] din;
  logic              lzb;
  logic [0:3]        z;
  logic [NDIG-1:0]   an;
  logic              pending;
  logic              frame;
  logic              dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_print = 0;

  logic [W-1:0] exp_q[$];

  logic [3:0] an_lit[NDIG] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  bcd_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .lzb       (lzb),
    .z         (z),
    .an        (an),
    .pending   (pending),
    .frame     (frame),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // behavioural model: position in the scan is plain arithmetic on the
  // number of edges since reset release
  int          m_e = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  logic        m_pending = 1'b0;
  logic        m_frame = 1'b0;

  always @(posedge clk) begin
    logic       wrap;
    logic [3:0] e_an;
    logic [3:0] e_z;
    int         p, d, ph;
    if (!rst_n) begin
      m_e       = 0;
      m_active  = '0;
      m_shadow  = '0;
      m_pending = 1'b0;
      m_frame   = 1'b0;
    end else begin
      m_e++;
      wrap = (m_e >= BLANK) && (((m_e - BLANK) % FP) == 0);
      if (wrap && m_pending) m_active = m_shadow;
      if (load) begin
        m_shadow  = din;
        m_pending = 1'b1;
      end else if (wrap) begin
        m_pending = 1'b0;
      end
      m_frame = wrap;
    end
    e_an = 4'hF;
    e_z  = 4'hF;
    if (rst_n && m_e >= BLANK) begin
      p  = (m_e - BLANK) % FP;
      d  = p / DP;
      ph = p % DP;
      if (ph < DIV) begin
        e_an = ~(4'(1) << d);
        e_z  = m_active[4*d +: 4];
        if (lzb && d > 0 && (m_active >> (4*d)) == 16'd0) e_z = 4'hF;
      end
    end
    exp_q.push_back({e_an, e_z, m_pending, m_frame});
  end

  // scoreboard: compare every cycle, just after the edge
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {an, z, pending, frame};
        n_total++;
        if (a === e) begin
          n_pass++;
        end else begin
          if (n_print < 30)
            $display("FAIL cycle_cmp t=%0t an=%b/%b z=%h/%h pending=%b/%b frame=%b/%b (got/exp)",
                     $time, a[9:6], e[9:6], a[5:2], e[5:2], a[1], e[1], a[0], e[0]);
          n_print++;
        end
      end
    end
  end

  // driver / checker tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  task automatic drive_load(input logic [15:0] v);
    @(negedge clk);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    for (int i = 0; i < FP + 5; i++) begin
      @(posedge clk);
      #1;
      if (frame === 1'b1) return;
    end
    n_total++;
    $display("FAIL %s timeout waiting for frame got=0 expected=1", name);
  endtask

  task automatic wait_an(input string name, input logic [3:0] v);
    for (int i = 0; i < FP + 5; i++) begin
      @(posedge clk);
      #1;
      if (an === v) return;
    end
    n_total++;
    $display("FAIL %s timeout waiting for an got=%b expected=%b", name, an, v);
  endtask

  // walk one whole frame from the wrap cycle; zexp holds the expected z per digit
  task automatic check_frame(input string name, input logic [15:0] zexp);
    int d, ph;
    for (int j = 0; j < FP; j++) begin
      d  = j / DP;
      ph = j % DP;
      if (ph < DIV) begin
        chk({name, "_an"}, 32'(an), 32'(an_lit[d]));
        chk({name, "_z"}, 32'(z), 32'(zexp[4*d +: 4]));
      end else begin
        chk({name, "_blank_an"}, 32'(an), 32'hF);
        chk({name, "_blank_z"}, 32'(z), 32'hF);
      end
      @(posedge clk);
      #1;
    end
    chk({name, "_frame_period"}, 32'(frame), 32'd1);
  endtask

  // stimulus
  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    din   = '0;
    lzb   = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = 1'($urandom_range(0, 1));
      din  = 16'($urandom);
    end
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_z", 32'(z), 32'hF);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_wrap_an", 32'(an), 32'b1110);
    chk("first_wrap_frame", 32'(frame), 32'd1);
    chk("first_wrap_z", 32'(z), 32'd0);
    @(posedge clk);
    #1;
    chk("frame_one_clock", 32'(frame), 32'd0);

    // scan order
    drive_load(16'h4321);
    chk("scan_pending", 32'(pending), 32'd1);
    wait_frame("scan_wait");
    chk("scan_pending_clr", 32'(pending), 32'd0);
    check_frame("scan", 16'h4321);

    // tearing: load while digit 2 is lit
    wait_an("tear_wait2", 4'b1011);
    drive_load(16'h1234);
    chk("tear_an2", 32'(an), 32'b1011);
    chk("tear_z2", 32'(z), 32'd3);
    chk("tear_pending", 32'(pending), 32'd1);
    wait_an("tear_wait3", 4'b0111);
    chk("tear_z3_old", 32'(z), 32'd4);
    chk("tear_pending3", 32'(pending), 32'd1);
    wait_frame("tear_wrap");
    chk("tear_pending_clr", 32'(pending), 32'd0);
    check_frame("tear_new", 16'h1234);

    // load exactly on the wrap edge
    drive_load(16'h5555);
    repeat (18) @(negedge clk);
    load = 1'b1;
    din  = 16'h6666;
    @(negedge clk);
    load = 1'b0;
    chk("simul_frame", 32'(frame), 32'd1);
    chk("simul_pending", 32'(pending), 32'd1);
    chk("simul_z", 32'(z), 32'd5);
    check_frame("simul_5555", 16'h5555);
    check_frame("simul_6666", 16'h6666);
    chk("simul_pending_clr", 32'(pending), 32'd0);

    // leading-zero suppression
    drive_load(16'h0070);
    wait_frame("lz_w1");
    wait_frame("lz_w2");
    check_frame("lz_off", 16'h0070);
    @(negedge clk);
    lzb = 1'b1;
    wait_frame("lz_w3");
    check_frame("lz_on", 16'hFF70);
    drive_load(16'h0000);
    wait_frame("lz_w4");
    wait_frame("lz_w5");
    check_frame("lz_zero", 16'hFFF0);
    @(negedge clk);
    lzb = 1'b0;

    // reset mid-frame with a pending value
    drive_load(16'h9876);
    repeat (5) @(negedge clk);
    chk("mid_pending", 32'(pending), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_z", 32'(z), 32'hF);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = 1'($urandom_range(0, 1));
      din  = 16'($urandom);
    end
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_wrap_frame", 32'(frame), 32'd1);
    check_frame("mid_after", 16'h0000);

    // randomized run, checked by the scoreboard
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) != 0);
      load  = ($urandom_range(0, 15) == 0);
      din   = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0) lzb = ~lzb;
    end
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexing scan controller that shares a single BCD-to-7-segment decoder (`z[0:3]` input, active-low segment outputs) across `NDIG` common-anode digits. It holds a double-buffered multi-digit BCD value and steps through the digits, one at a time, on a fixed refresh period. A blanking interval between digits suppresses ghosting. Optional leading-zero suppression is provided. It sits between the counting/arithmetic logic that produces the BCD value and the shared decoder plus anode drivers on the board.

## Interface
- `NDIG`, 4: number of digits scanned (2..8).
- `DIV`, 50000: clocks each digit is lit (SHOW phase), ≥1.
- `BLANK`, 2: clocks all anodes are off between digits (BLANK phase), ≥1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load`  in  1  when high at a clock edge, capture `din` into the shadow register.
- `din`  in  4*NDIG  BCD digits; `din[3:0]` is digit 0 (least significant).
- `lzb`  in  1  leading-zero blanking enable (level, sampled continuously).
- `z`  out  [0:3]  BCD code to the decoder; `z[0]` is the MSB; 4'b1111 means blank.
- `an`  out  NDIG  anode enables, active-low, at most one low at a time.
- `pending`  out  1  shadow holds a value not yet displayed.
- `frame`  out  1  one-clock pulse at each frame wrap (digit NDIG-1 → 0).

## Operation
- Registers: `active` (4*NDIG), `shadow` (4*NDIG), `pending`, `idx` (digit index), `cnt` (phase counter), `state` ∈ {SHOW, BLANK}.
- Outputs are Moore outputs. `an` and `z` are decoded from `state`, `idx`, `active` and `lzb` only, with no dependence on `load` or `din`.
- SHOW: `an[idx]`=0, others 1; `z` = `active[4*idx+3 -: 4]` unless suppressed. `cnt` counts 0..DIV-1. At DIV-1 go to BLANK with `cnt`←0.
- BLANK: `an` all 1, `z`=4'b1111. `cnt` counts 0..BLANK-1. At BLANK-1 go to SHOW with `cnt`←0 and `idx`←`idx`+1, wrapping NDIG-1→0.
- Frame wrap is the BLANK→SHOW edge where `idx` goes NDIG-1→0:
  - `frame`=1 for that one clock (registered, asserted the cycle the new frame's digit 0 first shows).
  - If `pending`=1: `active`←`shadow` (pre-edge value) and `pending`←0.
- Load: on an edge with `load`=1, `shadow`←`din` and `pending`←1.
- Load coinciding with the wrap edge:
  - `active` takes the old `shadow`.
  - `shadow` takes `din`.
  - `pending` ends at 1, so the new value shows next frame.
  - Load wins over the clear.
- `active` changes only at frame wrap. A displayed frame never mixes two loads (no tearing).
- Leading-zero suppression (`lzb`=1): digit k>0 is blanked (`z`=4'b1111, anode still driven low) if `active` digits NDIG-1 down to k are all 0. Digit 0 is never suppressed.
- Non-BCD codes (10..15) in `active` pass through unchanged on `z`. The decoder displays them as blank.

## Timing
- Reset (async assert, sync release):
  - `state`=BLANK, `idx`=NDIG-1, `cnt`=0.
  - `active`=0, `shadow`=0, `pending`=0, `frame`=0.
  - Outputs during reset: `an`=all 1, `z`=4'b1111.
- First wrap happens BLANK clocks after reset release. Digit 0 is lit on edge BLANK, and `frame` pulses on that edge.
- Digit period: DIV+BLANK clocks. Frame period: NDIG*(DIV+BLANK) clocks.
- Load-to-display latency: from the load edge to the next wrap edge; maximum one frame period.
- Reset mid-scan returns immediately to the reset state. A pending shadow is discarded.
- `an` never has two bits low. Every digit change passes through ≥BLANK clocks of all-off.

## Test plan
- Reset: hold `rst_n`=0 with random `load`/`din` → `an`=4'b1111, `z`=4'b1111, `pending`=0. Release → `an`=4'b1110 exactly BLANK clocks later, with `frame`=1 for that one clock.
- Scan order (NDIG=4, DIV=4, BLANK=1, after load 16'h4321) → per digit, 4 clocks of `an`=1110/1101/1011/0111 with `z`=1,2,3,4 respectively. Each is separated by 1 clock of `an`=1111, `z`=1111. `frame` period is 20 clocks.
- Tearing: load 16'h1234 while digit 2 is showing → remaining digits still show the old value. `pending`=1 until the wrap, then 0. The next frame shows 4,3,2,1.
- Simultaneous: load 16'h5555, then load 16'h6666 exactly on the wrap edge → that frame shows 5555, `pending` stays 1, and the following frame shows 6666.
- Leading zeros: `active`=16'h0070, `lzb`=1 → digits 3 and 2 give `z`=1111, digit 1 gives 7, digit 0 gives 0. For 16'h0000, only digit 0 shows 0. With `lzb`=0, all digits show their codes.
- Reset mid-frame with `pending`=1 → returns to reset values, and the first frame after release shows 0000.
